// File: rtl/vector_issue_pkg.sv
// Shared encodings, FSM states and the control-bundle layout for the vector issue controller.
package vector_issue_pkg;

    localparam logic [1:0] OPT_ALU = 2'b00;
    localparam logic [1:0] OPT_IMM = 2'b01;
    localparam logic [1:0] OPT_MEM = 2'b10;
    localparam logic [1:0] OPT_BR  = 2'b11;

    localparam logic [3:0] MEM_LD  = 4'b0000;
    localparam logic [3:0] MEM_ST  = 4'b0001;
    localparam logic [3:0] MEM_VLD = 4'b1000;
    localparam logic [3:0] MEM_VST = 4'b1001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCALAR,
        ST_VECTOR
    } state_t;

    typedef struct packed {
        logic       immSrc;
        logic       branchFlag;
        logic       memWrite;
        logic       memToReg;
        logic       regWrite;
        logic       regWriteV;
        logic       modeSel;
        logic [3:0] aluControl;
        logic       illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/vector_issue_ctrl_decode.sv
// Purely combinational instruction decoder: (op_type, op_code, rd) -> ctrl_bundle_t.
module ctrl_decode
    import vector_issue_pkg::*;
#(
    parameter int RF_AW = 4
) (
    input  logic [1:0]       op_type,
    input  logic [3:0]       op_code,
    input  logic [RF_AW-1:0] rd,
    output ctrl_bundle_t     ctrl
);

    logic rdNonZero;
    assign rdNonZero = (rd != '0);

    always_comb begin
        ctrl = '0;
        case (op_type)
            OPT_ALU, OPT_IMM: begin
                ctrl.aluControl = {1'b0, op_code[2:0]};
                ctrl.immSrc     = (op_type == OPT_IMM);
                ctrl.modeSel    = op_code[3];
                ctrl.regWrite   = !op_code[3] && rdNonZero;
                ctrl.regWriteV  = op_code[3];
            end
            OPT_MEM: begin
                ctrl.immSrc     = 1'b1;
                ctrl.aluControl = ALU_ADD;
                case (op_code)
                    MEM_LD: begin
                        ctrl.memToReg = 1'b1;
                        ctrl.regWrite = rdNonZero;
                    end
                    MEM_ST:  ctrl.memWrite = 1'b1;
                    MEM_VLD: begin
                        ctrl.memToReg  = 1'b1;
                        ctrl.regWriteV = 1'b1;
                        ctrl.modeSel   = 1'b1;
                    end
                    MEM_VST: begin
                        ctrl.memWrite = 1'b1;
                        ctrl.modeSel  = 1'b1;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            default: begin
                // Branches never write and always run scalar, whatever op_code[3] says.
                ctrl.branchFlag = 1'b1;
                ctrl.immSrc     = 1'b1;
                ctrl.aluControl = ALU_SUB;
            end
        endcase
    end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Registered, handshaked issue controller that replays each vector op for VLEN/LANES beats.
// Optional perf counters (issue_cnt, beat_cnt) are built when VECTOR_ISSUE_PERF_EN is defined.
module vector_issue_ctrl
    import vector_issue_pkg::*;
#(
    parameter int VLEN  = 8,
    parameter int LANES = 4,
    parameter int RF_AW = 4,
`ifdef VECTOR_ISSUE_PERF_EN
    parameter int CNT_W = 32,
`endif
    localparam int BEATS  = VLEN / LANES,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_type,
    input  logic [3:0]        op_code,
    input  logic [RF_AW-1:0]  rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              imm_src,
    output logic              branch_flag,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              reg_write_v,
    output logic              mode_sel,
    output logic [3:0]        alu_control,
    output logic [RF_AW-1:0]  rd_out,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              last_beat,
`ifdef VECTOR_ISSUE_PERF_EN
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  beat_cnt,
`endif
    output logic              illegal
);

    localparam logic [BEAT_W-1:0] LAST_IDX   = BEAT_W'(BEATS - 1);
    localparam logic              MULTI_BEAT = (BEATS > 1);

    state_t             stateReg, stateNext;
    logic               validReg, validNext;
    ctrl_bundle_t       bundleReg, bundleNext, decoded;
    logic [RF_AW-1:0]   rdReg, rdNext;
    logic [BEAT_W-1:0]  beatReg, beatNext;
    logic               lastReg, lastNext;
    logic               inReady, accept, handshake, goVector;

    ctrl_decode #(.RF_AW(RF_AW)) uDecode (
        .op_type (op_type),
        .op_code (op_code),
        .rd      (rd),
        .ctrl    (decoded)
    );

    // A new op may enter only when the slot is empty or its final beat is leaving now.
    assign inReady   = !rst && !flush && (stateReg == ST_IDLE || (out_ready && lastReg));
    assign accept    = in_valid && inReady;
    assign handshake = validReg && out_ready;
    assign goVector  = decoded.modeSel && MULTI_BEAT;

    always_comb begin
        stateNext  = stateReg;
        validNext  = validReg;
        bundleNext = bundleReg;
        rdNext     = rdReg;
        beatNext   = beatReg;
        lastNext   = lastReg;
        if (flush) begin
            stateNext = ST_IDLE;
            validNext = 1'b0;
            beatNext  = '0;
            lastNext  = 1'b0;
        end else if (accept) begin
            stateNext  = goVector ? ST_VECTOR : ST_SCALAR;
            validNext  = 1'b1;
            bundleNext = decoded;
            rdNext     = rd;
            beatNext   = '0;
            lastNext   = !goVector;
        end else if (handshake) begin
            if (stateReg == ST_VECTOR && !lastReg) begin
                beatNext = beatReg + BEAT_W'(1);
                lastNext = ((beatReg + BEAT_W'(1)) == LAST_IDX);
            end else begin
                stateNext = ST_IDLE;
                validNext = 1'b0;
                beatNext  = '0;
                lastNext  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= ST_IDLE;
            validReg  <= 1'b0;
            bundleReg <= '0;
            rdReg     <= '0;
            beatReg   <= '0;
            lastReg   <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            validReg  <= validNext;
            bundleReg <= bundleNext;
            rdReg     <= rdNext;
            beatReg   <= beatNext;
            lastReg   <= lastNext;
        end
    end

`ifdef VECTOR_ISSUE_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (accept)    issue_cnt <= issue_cnt + CNT_W'(1);
            if (handshake) beat_cnt  <= beat_cnt + CNT_W'(1);
        end
    end
`endif

    assign in_ready    = inReady;
    assign out_valid   = validReg;
    assign imm_src     = bundleReg.immSrc;
    assign branch_flag = bundleReg.branchFlag;
    assign mem_write   = bundleReg.memWrite;
    assign mem_to_reg  = bundleReg.memToReg;
    assign reg_write   = bundleReg.regWrite;
    assign reg_write_v = bundleReg.regWriteV;
    assign mode_sel    = bundleReg.modeSel;
    assign alu_control = bundleReg.aluControl;
    assign illegal     = bundleReg.illegal;
    assign rd_out      = rdReg;
    assign beat_idx    = beatReg;
    assign last_beat   = lastReg;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Directed scoreboard bench for vector_issue_ctrl (VLEN=8, LANES=4 -> 2 beats per vector op).
module tb_vector_issue_ctrl;

    localparam int VLEN  = 8;
    localparam int LANES = 4;
    localparam int RF_AW = 4;
    localparam int BEATS = VLEN / LANES;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic             imm_src, branch_flag, mem_write, mem_to_reg, reg_write, reg_write_v, mode_sel;
    logic             last_beat, illegal;
    logic [1:0]       op_type;
    logic [3:0]       op_code, alu_control;
    logic [RF_AW-1:0] rd, rd_out;
    logic [0:0]       beat_idx;
`ifdef VECTOR_ISSUE_PERF_EN
    logic [31:0]      issue_cnt, beat_cnt;
`endif

    always #5 clk = ~clk;

    vector_issue_ctrl #(.VLEN(VLEN), .LANES(LANES), .RF_AW(RF_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_type     (op_type),
        .op_code     (op_code),
        .rd          (rd),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .imm_src     (imm_src),
        .branch_flag (branch_flag),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .reg_write_v (reg_write_v),
        .mode_sel    (mode_sel),
        .alu_control (alu_control),
        .rd_out      (rd_out),
        .beat_idx    (beat_idx),
        .last_beat   (last_beat),
`ifdef VECTOR_ISSUE_PERF_EN
        .issue_cnt   (issue_cnt),
        .beat_cnt    (beat_cnt),
`endif
        .illegal     (illegal)
    );

    typedef struct {
        logic [11:0]      ctl;
        logic [RF_AW-1:0] rdv;
        logic             beat;
        logic             last;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   waits;

    function automatic logic [11:0] mk(input logic [3:0] alu, input logic imm, br, mw, mtr, rw, rwv, mode, ill);
        return {alu, imm, br, mw, mtr, rw, rwv, mode, ill};
    endfunction

    function automatic logic [11:0] obsCtl();
        return {alu_control, imm_src, branch_flag, mem_write, mem_to_reg,
                reg_write, reg_write_v, mode_sel, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pushOp(input logic vec, input logic [11:0] ctl, input logic [RF_AW-1:0] rdv);
        int n;
        exp_t e;
        n = vec ? BEATS : 1;
        for (int b = 0; b < n; b++) begin
            e.ctl  = ctl;
            e.rdv  = rdv;
            e.beat = b[0];
            e.last = (b == n - 1);
            expQ.push_back(e);
        end
    endtask

    // Score the beat on the bus if it is being consumed, then advance one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                check("unexpected_beat", {31'd0, out_valid}, 32'd0);
            end else begin
                e = expQ.pop_front();
                check("bundle", {20'd0, obsCtl()}, {20'd0, e.ctl});
                check("rd_out", {28'd0, rd_out}, {28'd0, e.rdv});
                check("beat_idx", {31'd0, beat_idx}, {31'd0, e.beat});
                check("last_beat", {31'd0, last_beat}, {31'd0, e.last});
                $display("beat: ctl=%03h rd=%0d idx=%0d last=%0d", obsCtl(), rd_out, beat_idx, last_beat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] c, input logic [RF_AW-1:0] r, output int w);
        in_valid = 1'b1;
        op_type  = t;
        op_code  = c;
        rd       = r;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) check("issue_timeout", {31'd0, in_ready}, 32'd1);
        $display("issue: type=%b code=%b rd=%0d waits=%0d", t, c, r, w);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op_type = '0; op_code = '0; rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {7'd0, out_valid, obsCtl(), rd_out, beat_idx, last_beat},
              32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Scalar ALU, then the same op targeting r0 back-to-back.
        out_ready = 1'b1;
        pushOp(1'b0, mk(4'b0010, 0, 0, 0, 0, 1, 0, 0, 0), 4'd3);
        issue(2'b00, 4'b0010, 4'd3, waits);
        check("scalar_latency", {31'd0, out_valid}, 32'd1);
        pushOp(1'b0, mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0), 4'd0);
        issue(2'b00, 4'b0010, 4'd0, waits);
        check("scalar_no_bubble", waits, 32'd0);
        tick();
        check("idle_after_scalar", {31'd0, out_valid}, 32'd1 - 32'd1);

        // Vector ALU: two beats, in_ready low on beat 0.
        pushOp(1'b1, mk(4'b0011, 0, 0, 0, 0, 0, 1, 1, 0), 4'd4);
        issue(2'b00, 4'b1011, 4'd4, waits);
        #1;
        check("in_ready_beat0", {31'd0, in_ready}, 32'd0);
        tick();
        check("in_ready_beat1", {31'd0, in_ready}, 32'd1);
        tick();
        check("idle_after_vec", {31'd0, out_valid}, 32'd0);

        // Backpressure on beat 0 of a VLD.
        out_ready = 1'b0;
        pushOp(1'b1, mk(4'b0000, 1, 0, 0, 1, 0, 1, 1, 0), 4'd6);
        issue(2'b10, 4'b1000, 4'd6, waits);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_beat_idx", {31'd0, beat_idx}, 32'd0);
            check("bp_last", {31'd0, last_beat}, 32'd0);
            check("bp_bundle", {20'd0, obsCtl()}, {20'd0, expQ[0].ctl});
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("idle_after_bp", {31'd0, out_valid}, 32'd0);

        // Back-to-back ST, branch (op_code[3] set), VST.
        pushOp(1'b0, mk(4'b0000, 1, 0, 1, 0, 0, 0, 0, 0), 4'd5);
        issue(2'b10, 4'b0001, 4'd5, waits);
        pushOp(1'b0, mk(4'b0001, 1, 1, 0, 0, 0, 0, 0, 0), 4'd1);
        issue(2'b11, 4'b1000, 4'd1, waits);
        check("b2b_branch_waits", waits, 32'd0);
        pushOp(1'b1, mk(4'b0000, 1, 0, 1, 0, 0, 0, 1, 0), 4'd2);
        issue(2'b10, 4'b1001, 4'd2, waits);
        check("b2b_vst_waits", waits, 32'd0);
        tick();
        tick();
        check("idle_after_b2b", {31'd0, out_valid}, 32'd0);

        // Illegal memory encoding.
        pushOp(1'b0, mk(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1), 4'd7);
        issue(2'b10, 4'b0101, 4'd7, waits);
        tick();

        // Flush on beat 0 of a vector op while a new op is offered.
        out_ready = 1'b0;
        issue(2'b01, 4'b1100, 4'd9, waits);
        check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; in_valid = 1'b1; op_type = 2'b00; op_code = 4'b0001; rd = 4'd1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_beat_idx", {31'd0, beat_idx}, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush_no_accept", {31'd0, out_valid}, 32'd0);

        // Reset during beat 1 of a vector op.
        pushOp(1'b1, mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0), 4'd8);
        issue(2'b00, 4'b1000, 4'd8, waits);
        tick();
        check("mid_vec_beat", {31'd0, beat_idx}, 32'd1);
        void'(expQ.pop_back());
        rst = 1'b1; out_ready = 1'b0;
        tick();
        check("rst_outputs", {7'd0, out_valid, obsCtl(), rd_out, beat_idx, last_beat}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef VECTOR_ISSUE_PERF_EN
        check("issue_cnt_reset", issue_cnt, 32'd0);
        check("beat_cnt_reset", beat_cnt, 32'd0);
`endif
        out_ready = 1'b1;
        pushOp(1'b1, mk(4'b0101, 0, 0, 0, 0, 0, 1, 1, 0), 4'd10);
        issue(2'b00, 4'b1101, 4'd10, waits);
        tick();
        tick();
`ifdef VECTOR_ISSUE_PERF_EN
        check("issue_cnt_one", issue_cnt, 32'd1);
        check("beat_cnt_two", beat_cnt, 32'd2);
`endif
        check("final_idle", {31'd0, out_valid}, 32'd0);
        check("queue_drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
